// File: rtl/conv_window_gen_pkg.sv
// Shared defaults and helpers for the convolution window generator and its MAC consumer.
package conv_window_gen_pkg;

    localparam int unsigned DEF_I_BIT_WIDTH = 8;
    localparam int unsigned DEF_K_SIZE      = 3;
    localparam int unsigned DEF_IMG_W       = 28;
    localparam int unsigned DEF_IMG_H       = 28;

    // Window element (x,y) slot index inside the packed window; shared with the MAC stage.
    function automatic int unsigned win_idx(input int unsigned k,
                                            input int unsigned x,
                                            input int unsigned y);
        return k * x + y;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay line: circular RAM of DEPTH entries with a wrapping pointer.
// Ports:
//   clk, rst_n  clock and async active-low reset (pointer only; RAM contents not reset)
//   en          accepted beat: write din, advance pointer
//   din         pixel entering the delay
//   dout_c      pixel written DEPTH accepted beats ago (combinational RAM read)
module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned I_BIT_WIDTH = DEF_I_BIT_WIDTH,
    parameter int unsigned DEPTH       = DEF_IMG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [I_BIT_WIDTH-1:0] din,
    output logic [I_BIT_WIDTH-1:0] dout_c
);

    localparam int unsigned PW = cnt_width(DEPTH);

    logic [I_BIT_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          ptr_d;

    // Pointer advance with wrap at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is intentionally unreset; stale entries are masked by the frame counters.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

    // Read-before-write: the slot about to be overwritten holds the pixel one row back.
    assign dout_c = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// K x K sliding-window generator over a raster pixel stream ("valid" convolution, no padding).
// Ports:
//   clk, rst_n   clock and async active-low reset
//   in_valid     in_pixel accepted this cycle (no backpressure)
//   in_pixel     signed pixel, raster order
//   win_valid    win_data holds a complete window
//   win_data     packed window, element (x,y) at slot K*x+y
//   win_last     last window of the frame (with win_valid)
//   frame_done   one-cycle pulse after the frame's final pixel is accepted
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned I_BIT_WIDTH = DEF_I_BIT_WIDTH,
    parameter int unsigned K_SIZE      = DEF_K_SIZE,
    parameter int unsigned IMG_W       = DEF_IMG_W,
    parameter int unsigned IMG_H       = DEF_IMG_H
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [I_BIT_WIDTH-1:0]                in_pixel,
    output logic                                  win_valid,
    output logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]  win_data,
    output logic                                  win_last,
    output logic                                  frame_done
);

    localparam int unsigned W  = I_BIT_WIDTH;
    localparam int unsigned K  = K_SIZE;
    localparam int unsigned DW = W * K * K;
    localparam int unsigned CW = cnt_width(IMG_W);
    localparam int unsigned RW = cnt_width(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] win_q, win_d;
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic          frame_done_q, frame_done_d;

    logic [W-1:0]  lb_dout [K-1];
    logic [W-1:0]  tap [K];
    logic          col_end;
    logic          row_end;

    // Cascaded row delays: buffer i outputs the pixel i+1 rows above the incoming one.
    for (genvar i = 0; i < int'(K) - 1; i++) begin : g_lb
        logic [W-1:0] lb_din;
        if (i == 0) begin : g_first
            assign lb_din = in_pixel;
        end else begin : g_chain
            assign lb_din = lb_dout[i-1];
        end

        conv_line_buffer #(
            .I_BIT_WIDTH (W),
            .DEPTH       (IMG_W)
        ) u_lb (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (in_valid),
            .din    (lb_din),
            .dout_c (lb_dout[i])
        );
    end

    // Column taps ordered oldest row (x=0) to newest row (x=K-1).
    always_comb begin
        tap[K-1] = in_pixel;
        for (int unsigned i = 0; i < K - 1; i++) begin
            tap[K-2-i] = lb_dout[i];
        end
    end

    // Raster counters, window shift and registered output flags.
    always_comb begin
        col_end      = (col_q == CW'(IMG_W - 1));
        row_end      = (row_q == RW'(IMG_H - 1));
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        win_last_d   = 1'b0;
        frame_done_d = 1'b0;

        if (in_valid) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            // Each row of the window shifts left by one column; the new column enters at y=K-1.
            for (int unsigned x = 0; x < K; x++) begin
                for (int unsigned y = 0; y < K; y++) begin
                    if (y < K - 1) begin
                        win_d[W*win_idx(K, x, y) +: W] = win_q[W*win_idx(K, x, y + 1) +: W];
                    end else begin
                        win_d[W*win_idx(K, x, y) +: W] = tap[x];
                    end
                end
            end

            // Windows straddling the left edge hold previous-row columns and stay unflagged.
            win_valid_d  = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
            win_last_d   = col_end && row_end;
            frame_done_d = col_end && row_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_q;
    assign win_last   = win_last_q;
    assign frame_done = frame_done_q;

endmodule
